// File: rtl/proc_mem_pkg.sv
// ============================================================================
// Module  : proc_mem_pkg
// Brief   : Loader FSM states and memory request type codes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package proc_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/proc_mem_loader_if.sv
// ============================================================================
// Module  : proc_mem_loader_if
// Brief   : Upstream word stream plus zero-latency data memory port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface proc_mem_loader_if;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;

  modport master (
    input  in_val, in_data, dmemresp_rdata,
    output in_rdy, dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata
  );

  modport slave (
    output in_val, in_data, dmemresp_rdata,
    input  in_rdy, dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata
  );
endinterface

`default_nettype wire

// File: rtl/checksum_acc.sv
// ============================================================================
// Module  : checksum_acc
// Brief   : 32-bit modulo-2^32 accumulator with synchronous clear.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module checksum_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sum
);

  logic [31:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sum <= 32'd0;
    end else if (en) begin
      r_sum <= r_sum + din;
    end
  end

  assign sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/proc_mem_loader.sv
// ============================================================================
// Module  : proc_mem_loader
// Brief   : Streams words into data memory, reads them back, checks checksum.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module proc_mem_loader
  import proc_mem_pkg::*;
#(
  parameter int MAX_WORDS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              base_addr,
  input  logic [6:0]               num_words,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  proc_mem_loader_if.master        bus
);

  localparam logic [6:0] c_max_words = 7'(MAX_WORDS);

  state_t      r_state;
  logic [31:0] r_base;
  logic [6:0]  r_count;
  logic [6:0]  r_index;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic        r_in_rdy;

  logic [6:0]  w_count;
  logic        w_can_start;
  logic        w_start_ok;
  logic        w_xfer;
  logic        w_rd;
  logic        w_last;
  logic [31:0] w_addr;
  logic [31:0] w_wsum;
  logic [31:0] w_rsum;

  assign w_count     = (num_words > c_max_words) ? c_max_words : num_words;
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign w_start_ok  = start && w_can_start;
  // Requests are suppressed during the reset cycle so an abort never issues one.
  assign w_xfer      = !rst && (r_state == ST_LOAD) && bus.in_val;
  assign w_rd        = !rst && (r_state == ST_VERIFY);
  assign w_last      = (r_index == (r_count - 7'd1));
  assign w_addr      = r_base + {23'd0, r_index, 2'b00};

  always_comb begin
    bus.dmemreq_val   = w_xfer || w_rd;
    bus.dmemreq_type  = w_xfer ? MEM_WRITE : MEM_READ;
    bus.dmemreq_addr  = (w_xfer || w_rd) ? w_addr : 32'd0;
    bus.dmemreq_wdata = w_xfer ? bus.in_data : 32'd0;
  end

  assign bus.in_rdy = r_in_rdy && !rst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

  checksum_acc u_wsum (
    .clk (clk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (w_xfer),
    .din (bus.in_data),
    .sum (w_wsum)
  );

  checksum_acc u_rsum (
    .clk (clk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (w_rd),
    .din (bus.dmemresp_rdata),
    .sum (w_rsum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_base   <= 32'd0;
      r_count  <= 7'd0;
      r_index  <= 7'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_in_rdy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_base  <= base_addr & 32'hFFFF_FFFC;
            r_count <= w_count;
            r_index <= 7'd0;
            r_error <= 1'b0;
            if (w_count == 7'd0) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_in_rdy <= 1'b0;
            end else begin
              r_state  <= ST_LOAD;
              r_done   <= 1'b0;
              r_busy   <= 1'b1;
              r_in_rdy <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            if (w_last) begin
              r_index  <= 7'd0;
              r_state  <= ST_VERIFY;
              r_in_rdy <= 1'b0;
            end else begin
              r_index <= r_index + 7'd1;
            end
          end
        end
        ST_VERIFY: begin
          if (w_last) begin
            r_index <= 7'd0;
            r_state <= ST_CHECK;
          end else begin
            r_index <= r_index + 7'd1;
          end
        end
        ST_CHECK: begin
          r_busy <= 1'b0;
          if (w_rsum == w_wsum) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_in_rdy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_proc_mem_loader.sv
// ============================================================================
// Module  : tb_proc_mem_loader
// Brief   : Scoreboarded bench for proc_mem_loader with a zero-latency memory.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_proc_mem_loader;

  localparam int c_max = 8;

  typedef struct packed {
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [6:0]  num_words = 7'd0;
  logic        busy, done, error;
  logic        corrupt = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] mem [256];
  req_t        exp_q[$];

  proc_mem_loader_if bus ();

  proc_mem_loader #(.MAX_WORDS(c_max)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, optional bit-0 corruption of word 0x44.
  assign bus.dmemresp_rdata = mem[bus.dmemreq_addr[9:2]];
  always @(posedge clk) begin
    if (!rst && bus.dmemreq_val && bus.dmemreq_type)
      mem[bus.dmemreq_addr[9:2]] <= bus.dmemreq_wdata ^
        ((corrupt && bus.dmemreq_addr == 32'h44) ? 32'd1 : 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dmemreq_val) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", bus.dmemreq_addr, 32'hFFFF_FFFF);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        chk("req_type", {31'd0, bus.dmemreq_type}, {31'd0, e.typ});
        chk("req_addr", bus.dmemreq_addr, e.addr);
        chk("req_wdata", bus.dmemreq_wdata, e.wdata);
      end
    end
  end

  task automatic wait_end(input int max_cyc);
    int n = 0;
    while (!(done || error) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(done || error)) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input logic [31:0] base, input logic [6:0] num, input int gap,
                          input bit stray, input bit rnd, input bit exp_ok, input int exp_lat);
    logic [31:0] d[$];
    logic [31:0] a0;
    int n, t0;
    n  = (num > c_max) ? c_max : int'(num);
    a0 = base & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) d.push_back(rnd ? $urandom : 32'(i + 1));
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, a0 + 32'(4 * i), d[i]});
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, a0 + 32'(4 * i), 32'd0});
    start = 1'b1; base_addr = base; num_words = num;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    if (n > 0) begin
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("done_cleared", {30'd0, done, error}, 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_val = 1'b0; bus.in_data = 32'hDEAD_BEEF;
        if (stray && i == 1 && g == 0) begin
          start = 1'b1; base_addr = 32'h200; num_words = 7'd1;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      chk("in_rdy", {31'd0, bus.in_rdy}, 32'd1);
      bus.in_val = 1'b1; bus.in_data = d[i];
      @(posedge clk); #1;
    end
    bus.in_val = 1'b0; bus.in_data = 32'd0;
    wait_end(100);
    chk("done", {31'd0, done}, {31'd0, exp_ok});
    chk("error", {31'd0, error}, {31'd0, !exp_ok});
    chk("busy_end", {31'd0, busy}, 32'd0);
    if (exp_lat >= 0) chk("latency", 32'(cyc - t0), 32'(exp_lat));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {busy, done, error, bus.in_rdy, bus.dmemreq_val, bus.dmemreq_type}, 32'd0);
    chk({tag, "_addr"}, bus.dmemreq_addr, 32'd0);
    chk({tag, "_wdata"}, bus.dmemreq_wdata, 32'd0);
  endtask

  initial begin
    bus.in_val = 1'b0;
    bus.in_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_load(32'h0, 7'd4, 0, 1'b0, 1'b0, 1'b1, 9);
    run_load(32'h40, 7'd3, 2, 1'b1, 1'b1, 1'b1, -1);
    corrupt = 1'b1;
    run_load(32'h41, 7'd3, 0, 1'b0, 1'b1, 1'b0, -1);
    corrupt = 1'b0;
    run_load(32'h80, 7'd0, 0, 1'b0, 1'b1, 1'b1, 0);
    run_load(32'hFFFF_FFF8, 7'd3, 1, 1'b0, 1'b1, 1'b1, -1);
    run_load(32'h300, 7'd10, 0, 1'b0, 1'b1, 1'b1, -1);

    // Abort a 5-word load after its second word.
    start = 1'b1; base_addr = 32'h100; num_words = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i)});
      bus.in_val = 1'b1; bus.in_data = 32'hA0 + 32'(i);
      @(posedge clk); #1;
    end
    chk("pre_abort_queue", 32'(exp_q.size()), 32'd0);
    bus.in_data = 32'hA2;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_noreq", {31'd0, bus.dmemreq_val}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("post_abort");
    bus.in_val = 1'b0; bus.in_data = 32'd0;
    @(posedge clk); #1;
    run_load(32'h100, 7'd5, 0, 1'b0, 1'b1, 1'b1, 11);

    chk("done_error_excl", {31'd0, done && error}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
